tmr_job_controller: RTL and testbench
=====================================

# tmr_job_controller

Sequencer and majority-voter for three redundant add-one compute replicas. It accepts one job at a time, dispatches the operand to every enabled replica, and collects the three results. It returns a word-level majority-voted result with status, and retires a replica after repeated disagreement. It sits between the AXI slave register file and the replica datapaths in the fault-tolerant multi-core design.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- TIMEOUT, 16, max cycles from dispatch to a replica's done
- FAULT_LIMIT, 3, faults before a replica is disabled (1..3)
- MAX_RETRY, 1, re-dispatches after a no-majority vote

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  reset, synchronous, active-high
- req_valid  in  1  job request
- req_ready  out  1  high only in IDLE
- req_data  in  DATA_W  operand
- core_start  out  3  one-cycle start pulse per replica
- core_operand  out  DATA_W  operand to replicas, stable DISPATCH..VOTE
- core_done  in  3  one-cycle done pulse per replica
- core_result0/1/2  in  DATA_W  replica results, valid with done
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_data  out  DATA_W  voted result
- rsp_status  out  2  00 OK, 01 CORRECTED, 10 ERROR
- core_disabled  out  3  retired replicas
- fault_irq  out  1  one-cycle pulse when any core_disabled bit sets
- clear_faults  in  1  clears fault counters and core_disabled

## Operation
- FSM states: IDLE, DISPATCH, WAIT, VOTE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_data, latch enable mask = ~core_disabled, then go to DISPATCH.
- Fewer than 2 enabled at accept: skip dispatch and go to RESP with status ERROR, data 0.
- DISPATCH (1 cycle): core_start = enable mask; clear done flags and timeout counter; go to WAIT.
- WAIT: latch each enabled replica's result on its core_done; ignore done from disabled replicas and repeats.
- WAIT exits to VOTE when all enabled replicas are done or the counter reaches TIMEOUT.
- A timed-out replica is excluded from the vote and scores one fault.
- VOTE with 3 valid results:
  - All equal: OK.
  - Exactly two equal: CORRECTED, data = the agreeing value, odd replica scores one fault.
  - All differ: no majority.
- VOTE with 2 valid results: equal gives OK; different gives no majority. Fewer than 2 valid results: no majority.
- No majority: if retry count < MAX_RETRY, increment it and return to DISPATCH; otherwise ERROR with data 0, no faults charged.
- RESP: rsp_valid=1, rsp_data/rsp_status stable; on rsp_ready go to IDLE and clear the retry count.
- Fault counters: per replica, 2-bit, saturating at FAULT_LIMIT. Reaching FAULT_LIMIT sets core_disabled[i] and pulses fault_irq the same cycle.
- clear_faults: zeroes counters and core_disabled next edge in any state. The in-flight job keeps its latched mask.
- Fault scoring and clear_faults in the same cycle: clear wins.
- Reset (any state): FSM to IDLE. All outputs 0 except req_ready=1 after the reset cycle. Counters, mask and retry count cleared. Any in-flight job is dropped with no response.

## Timing
- Accept at edge T; DISPATCH during T+1 (core_start high); WAIT from T+2.
- core_done seen at T+2 gives VOTE at T+3 and rsp_valid at T+4. Minimum latency: 4 cycles.
- Timeout: VOTE occurs TIMEOUT+1 cycles after DISPATCH when some replica never responds.
- Each retry adds DISPATCH+WAIT+VOTE. core_operand is unchanged across retries.
- Back-to-back: req_ready rises the cycle after the rsp handshake.

## Structure
- Package tmr_pkg: state enum, rsp_status encodings (ST_OK, ST_CORRECTED, ST_ERROR), replica count constant 3.
- Sub-module tmr_voter3: combinational. Inputs are three results plus a valid mask; outputs are voted data, status, majority flag and per-replica disagree mask. It is reusable by other TMR blocks.

## Test plan
- All replicas return 0x0000_0006 for operand 5 at T+2 -> rsp_valid at T+4, data 0x6, status 00, no fault.
- Replica 1 returns 0xDEAD_BEEF, others 0x6 -> data 0x6, status 01. Repeat three times -> core_disabled=3'b010, fault_irq pulses once.
- Results 0x1, 0x2, 0x3 with MAX_RETRY=1 -> two DISPATCH pulses, then status 10, data 0, no faults.
- Replica 2 never asserts done -> VOTE at DISPATCH+TIMEOUT+1, status OK from the other two, replica 2 fault +1.
- Two replicas disabled, then a request -> no core_start, rsp status 10. Pulse clear_faults -> next job dispatches all three.
- Assert S_AXI_ARESET during WAIT -> next cycle all outputs 0, req_ready=1, no response; late core_done is ignored.

Source files
------------

// File: rtl/tmr_pkg.sv
// tmr_pkg: shared types and constants for the triple-modular-redundancy
// job controller and its voter.
//   N_REPLICA               number of redundant replicas
//   ST_OK/ST_CORRECTED/ST_ERROR  response status encodings
//   state_e                 controller FSM states
package tmr_pkg;

  localparam int unsigned N_REPLICA = 3;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_CORRECTED = 2'b01;
  localparam logic [1:0] ST_ERROR     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_VOTE,
    S_RESP
  } state_e;

endpackage

// File: rtl/tmr_voter3.sv
// tmr_voter3: combinational word-level majority voter over three results.
// Ports:
//   i_d0/i_d1/i_d2  candidate results
//   i_valid         which candidates take part in the vote
//   o_data          voted word (0 when there is no majority)
//   o_status        ST_OK / ST_CORRECTED / ST_ERROR
//   o_majority      a usable result was found
//   o_disagree      the odd replica out when two of three agree
module tmr_voter3
  import tmr_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]    i_d0,
  input  logic [DATA_W-1:0]    i_d1,
  input  logic [DATA_W-1:0]    i_d2,
  input  logic [N_REPLICA-1:0] i_valid,
  output logic [DATA_W-1:0]    o_data,
  output logic [1:0]           o_status,
  output logic                 o_majority,
  output logic [N_REPLICA-1:0] o_disagree
);

  logic w_e01, w_e02, w_e12;

  assign w_e01 = (i_d0 == i_d1);
  assign w_e02 = (i_d0 == i_d2);
  assign w_e12 = (i_d1 == i_d2);

  always_comb begin
    o_data     = '0;
    o_status   = ST_ERROR;
    o_majority = 1'b0;
    o_disagree = '0;
    case (i_valid)
      3'b111: begin
        if (w_e01 && w_e12) begin
          o_data = i_d0; o_status = ST_OK; o_majority = 1'b1;
        end else if (w_e01) begin
          o_data = i_d0; o_status = ST_CORRECTED; o_majority = 1'b1; o_disagree = 3'b100;
        end else if (w_e02) begin
          o_data = i_d0; o_status = ST_CORRECTED; o_majority = 1'b1; o_disagree = 3'b010;
        end else if (w_e12) begin
          o_data = i_d1; o_status = ST_CORRECTED; o_majority = 1'b1; o_disagree = 3'b001;
        end
      end
      3'b011: if (w_e01) begin o_data = i_d0; o_status = ST_OK; o_majority = 1'b1; end
      3'b101: if (w_e02) begin o_data = i_d0; o_status = ST_OK; o_majority = 1'b1; end
      3'b110: if (w_e12) begin o_data = i_d1; o_status = ST_OK; o_majority = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmr_job_controller.sv
// tmr_job_controller: accepts one job at a time, dispatches the operand to
// every enabled replica, collects results, majority-votes them and retires
// replicas that keep faulting.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   req_valid/req_ready/req_data           job request
//   core_start/core_operand                dispatch to replicas
//   core_done/core_result0..2              replica completion
//   rsp_valid/rsp_ready/rsp_data/rsp_status voted response
//   core_disabled/fault_irq/clear_faults   replica retirement
module tmr_job_controller
  import tmr_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned FAULT_LIMIT = 3,
  parameter int unsigned MAX_RETRY   = 1
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATA_W-1:0]    req_data,
  output logic [N_REPLICA-1:0] core_start,
  output logic [DATA_W-1:0]    core_operand,
  input  logic [N_REPLICA-1:0] core_done,
  input  logic [DATA_W-1:0]    core_result0,
  input  logic [DATA_W-1:0]    core_result1,
  input  logic [DATA_W-1:0]    core_result2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [1:0]           rsp_status,
  output logic [N_REPLICA-1:0] core_disabled,
  output logic                 fault_irq,
  input  logic                 clear_faults
);

  localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    F_LIM  = 2'(FAULT_LIMIT);
  localparam logic [7:0]    R_MAX  = 8'(MAX_RETRY);

  state_e               r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_operand, r_rsp_data, w_vdata;
  logic [DATA_W-1:0]    r_res    [N_REPLICA];
  logic [DATA_W-1:0]    w_result [N_REPLICA];
  logic [1:0]           r_fcnt   [N_REPLICA];
  logic [1:0]           r_rsp_status, w_vstatus;
  logic [N_REPLICA-1:0] r_mask, r_done, r_disabled;
  logic [N_REPLICA-1:0] w_done_nxt, w_enabled, w_fault, w_disagree;
  logic [TW-1:0]        r_tcnt;
  logic [7:0]           r_retry;
  logic                 r_irq;
  logic                 w_enough, w_wait_exit, w_majority, w_retry_ok;

  assign w_result[0] = core_result0;
  assign w_result[1] = core_result1;
  assign w_result[2] = core_result2;

  assign w_enabled   = ~r_disabled;
  assign w_enough    = (w_enabled[0] & w_enabled[1]) | (w_enabled[0] & w_enabled[2]) |
                       (w_enabled[1] & w_enabled[2]);
  // Only first done from a dispatched replica counts.
  assign w_done_nxt  = r_done | (core_done & r_mask);
  // WAIT lasts at most TIMEOUT cycles: counter is 0 in the first WAIT cycle.
  assign w_wait_exit = (w_done_nxt == r_mask) || (r_tcnt == T_LAST);
  assign w_retry_ok  = (r_retry < R_MAX);
  // Silent replicas are charged on every vote; the odd one out only when a
  // majority exists.
  assign w_fault     = (r_mask & ~r_done) | (w_majority ? w_disagree : '0);

  tmr_voter3 #(.DATA_W(DATA_W)) u_voter (
    .i_d0       (r_res[0]),
    .i_d1       (r_res[1]),
    .i_d2       (r_res[2]),
    .i_valid    (r_done),
    .o_data     (w_vdata),
    .o_status   (w_vstatus),
    .o_majority (w_majority),
    .o_disagree (w_disagree)
  );

  assign core_operand  = r_operand;
  assign rsp_data      = r_rsp_data;
  assign rsp_status    = r_rsp_status;
  assign core_disabled = r_disabled;
  assign fault_irq     = r_irq;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    core_start  = '0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_enough ? S_DISPATCH : S_RESP;
      end
      S_DISPATCH: begin
        core_start  = r_mask;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (w_wait_exit) w_state_nxt = S_VOTE;
      S_VOTE: begin
        if (!w_majority && w_retry_ok) w_state_nxt = S_DISPATCH;
        else                           w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_operand    <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_mask       <= '0;
      r_done       <= '0;
      r_disabled   <= '0;
      r_tcnt       <= '0;
      r_retry      <= '0;
      r_irq        <= 1'b0;
      for (int unsigned i = 0; i < N_REPLICA; i++) begin
        r_res[i]  <= '0;
        r_fcnt[i] <= '0;
      end
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_operand <= req_data;
            r_mask    <= w_enabled;
            r_retry   <= '0;
            if (!w_enough) begin
              r_rsp_data   <= '0;
              r_rsp_status <= ST_ERROR;
            end
          end
        end
        S_DISPATCH: begin
          r_done <= '0;
          r_tcnt <= '0;
        end
        S_WAIT: begin
          r_done <= w_done_nxt;
          r_tcnt <= r_tcnt + 1'b1;
          for (int unsigned i = 0; i < N_REPLICA; i++)
            if (w_done_nxt[i] && !r_done[i]) r_res[i] <= w_result[i];
        end
        S_VOTE: begin
          if (w_majority) begin
            r_rsp_data   <= w_vdata;
            r_rsp_status <= w_vstatus;
          end else if (w_retry_ok) begin
            r_retry <= r_retry + 8'd1;
          end else begin
            r_rsp_data   <= '0;
            r_rsp_status <= ST_ERROR;
          end
        end
        S_RESP: if (rsp_ready) r_retry <= '0;
        default: ;
      endcase

      // clear_faults takes priority over any fault scored this cycle.
      if (clear_faults) begin
        r_disabled <= '0;
        for (int unsigned i = 0; i < N_REPLICA; i++) r_fcnt[i] <= '0;
      end else if (r_state == S_VOTE) begin
        for (int unsigned i = 0; i < N_REPLICA; i++) begin
          if (w_fault[i] && !r_disabled[i]) begin
            r_fcnt[i] <= r_fcnt[i] + 2'd1;
            if (r_fcnt[i] + 2'd1 == F_LIM) begin
              r_disabled[i] <= 1'b1;
              r_irq         <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tmr_job_controller.sv
// tb_tmr_job_controller: directed self-checking bench for tmr_job_controller
// (default parameters: DATA_W=32, TIMEOUT=16, FAULT_LIMIT=3, MAX_RETRY=1).
module tb_tmr_job_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [2:0]  core_start;
  logic [31:0] core_operand;
  logic [2:0]  core_done = '0;
  logic [31:0] res0 = '0, res1 = '0, res2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [2:0]  core_disabled;
  logic        fault_irq;
  logic        clear_faults = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tmr_job_controller #(.DATA_W(32), .TIMEOUT(16), .FAULT_LIMIT(3), .MAX_RETRY(1)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .core_start    (core_start),
    .core_operand  (core_operand),
    .core_done     (core_done),
    .core_result0  (res0),
    .core_result1  (res1),
    .core_result2  (res2),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_status    (rsp_status),
    .core_disabled (core_disabled),
    .fault_irq     (fault_irq),
    .clear_faults  (clear_faults)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns just after the accept edge.
  task automatic send_req(input logic [31:0] op);
    req_valid = 1'b1;
    req_data  = op;
    step();
    req_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
    core_done = m; res0 = a; res1 = b; res2 = c;
    step();
    core_done = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_chk++; if (core_start !== 3'b000) begin n_err++; $display("FAIL reset_core_start got=%b exp=000", core_start); end
    n_chk++; if (core_disabled !== 3'b000) begin n_err++; $display("FAIL reset_disabled got=%b exp=000", core_disabled); end
    n_chk++; if (fault_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", fault_irq); end
    n_chk++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
  endtask

  task automatic test_all_agree();
    send_req(32'h5);                                  // DISPATCH
    n_chk++; if (core_start !== 3'b111) begin n_err++; $display("FAIL agree_start got=%b exp=111", core_start); end
    n_chk++; if (core_operand !== 32'h5) begin n_err++; $display("FAIL agree_operand got=%h exp=5", core_operand); end
    n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL agree_busy got=%b exp=0", req_ready); end
    step();                                           // WAIT (T+2)
    pulse_done(3'b111, 32'h6, 32'h6, 32'h6);          // VOTE (T+3)
    n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL agree_early_rsp got=%b exp=0", rsp_valid); end
    step();                                           // RESP (T+4)
    n_chk++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL agree_rsp_valid got=%b exp=1", rsp_valid); end
    n_chk++; if (rsp_data !== 32'h6) begin n_err++; $display("FAIL agree_data got=%h exp=6", rsp_data); end
    n_chk++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL agree_status got=%b exp=00", rsp_status); end
    step();                                           // held without rsp_ready
    n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h6) begin n_err++; $display("FAIL agree_hold got=%b/%h exp=1/6", rsp_valid, rsp_data); end
    handshake();
    n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready got=%b exp=1", req_ready); end
    n_chk++; if (core_disabled !== 3'b000) begin n_err++; $display("FAIL agree_no_fault got=%b exp=000", core_disabled); end
  endtask

  task automatic test_no_majority();
    send_req(32'h7);
    n_chk++; if (core_start !== 3'b111) begin n_err++; $display("FAIL nomaj_start1 got=%b exp=111", core_start); end
    step();
    pulse_done(3'b111, 32'h1, 32'h2, 32'h3);          // VOTE
    step();                                           // retry DISPATCH
    n_chk++; if (core_start !== 3'b111) begin n_err++; $display("FAIL nomaj_start2 got=%b exp=111", core_start); end
    n_chk++; if (core_operand !== 32'h7) begin n_err++; $display("FAIL nomaj_operand got=%h exp=7", core_operand); end
    step();
    pulse_done(3'b111, 32'h1, 32'h2, 32'h3);
    step();                                           // RESP
    n_chk++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL nomaj_rsp_valid got=%b exp=1", rsp_valid); end
    n_chk++; if (rsp_status !== 2'b10) begin n_err++; $display("FAIL nomaj_status got=%b exp=10", rsp_status); end
    n_chk++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL nomaj_data got=%h exp=0", rsp_data); end
    n_chk++; if (core_disabled !== 3'b000 || fault_irq !== 1'b0) begin n_err++; $display("FAIL nomaj_fault got=%b/%b exp=000/0", core_disabled, fault_irq); end
    handshake();
  endtask

  task automatic test_timeout();
    send_req(32'h8);                                  // DISPATCH at cycle D
    step();                                           // D+1
    pulse_done(3'b011, 32'h9, 32'h9, 32'h0);          // D+2
    repeat (15) step();                               // D+17: VOTE
    n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_early got=%b exp=0", rsp_valid); end
    step();                                           // D+18: RESP
    n_chk++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL tmo_rsp_valid got=%b exp=1", rsp_valid); end
    n_chk++; if (rsp_data !== 32'h9) begin n_err++; $display("FAIL tmo_data got=%h exp=9", rsp_data); end
    n_chk++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL tmo_status got=%b exp=00", rsp_status); end
    handshake();
  endtask

  task automatic test_corrected();
    for (int k = 0; k < 3; k++) begin
      send_req(32'h5);
      step();
      pulse_done(3'b111, 32'h6, 32'hDEAD_BEEF, 32'h6);
      step();
      n_chk++; if (rsp_data !== 32'h6) begin n_err++; $display("FAIL corr_data[%0d] got=%h exp=6", k, rsp_data); end
      n_chk++; if (rsp_status !== 2'b01) begin n_err++; $display("FAIL corr_status[%0d] got=%b exp=01", k, rsp_status); end
      n_chk++;
      if (core_disabled !== ((k == 2) ? 3'b010 : 3'b000)) begin
        n_err++; $display("FAIL corr_disabled[%0d] got=%b exp=%b", k, core_disabled, (k == 2) ? 3'b010 : 3'b000);
      end
      n_chk++;
      if (fault_irq !== ((k == 2) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL corr_irq[%0d] got=%b exp=%b", k, fault_irq, (k == 2) ? 1'b1 : 1'b0);
      end
      handshake();
    end
    n_chk++; if (fault_irq !== 1'b0) begin n_err++; $display("FAIL corr_irq_pulse got=%b exp=0", fault_irq); end
  endtask

  // Replica 1 already retired; replica 2 stays silent and is charged at
  // both votes of one job (second timeout charge after the earlier one).
  task automatic test_two_disabled();
    send_req(32'h10);
    n_chk++; if (core_start !== 3'b101) begin n_err++; $display("FAIL two_start1 got=%b exp=101", core_start); end
    step();
    pulse_done(3'b001, 32'h11, 32'h0, 32'h0);
    repeat (15) step();                               // VOTE
    step();                                           // retry DISPATCH
    n_chk++; if (core_start !== 3'b101) begin n_err++; $display("FAIL two_start2 got=%b exp=101", core_start); end
    n_chk++; if (core_disabled !== 3'b010) begin n_err++; $display("FAIL two_mid_disabled got=%b exp=010", core_disabled); end
    step();
    pulse_done(3'b001, 32'h11, 32'h0, 32'h0);
    repeat (15) step();
    step();                                           // RESP
    n_chk++; if (rsp_status !== 2'b10 || rsp_data !== 32'h0) begin n_err++; $display("FAIL two_err_rsp got=%b/%h exp=10/0", rsp_status, rsp_data); end
    n_chk++; if (core_disabled !== 3'b110) begin n_err++; $display("FAIL two_disabled got=%b exp=110", core_disabled); end
    n_chk++; if (fault_irq !== 1'b1) begin n_err++; $display("FAIL two_irq got=%b exp=1", fault_irq); end
    handshake();
    send_req(32'h20);                                 // straight to RESP
    n_chk++; if (core_start !== 3'b000) begin n_err++; $display("FAIL skip_start got=%b exp=000", core_start); end
    n_chk++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10) begin n_err++; $display("FAIL skip_rsp got=%b/%b exp=1/10", rsp_valid, rsp_status); end
    handshake();
    clear_faults = 1'b1;
    step();
    clear_faults = 1'b0;
    n_chk++; if (core_disabled !== 3'b000) begin n_err++; $display("FAIL clear_disabled got=%b exp=000", core_disabled); end
    send_req(32'h3);
    n_chk++; if (core_start !== 3'b111) begin n_err++; $display("FAIL clear_start got=%b exp=111", core_start); end
    step();
    pulse_done(3'b111, 32'h4, 32'h4, 32'h4);
    step();
    n_chk++; if (rsp_data !== 32'h4 || rsp_status !== 2'b00) begin n_err++; $display("FAIL clear_rsp got=%h/%b exp=4/00", rsp_data, rsp_status); end
    handshake();
  endtask

  task automatic test_reset_in_wait();
    send_req(32'h5);
    step();                                           // WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstw_req_ready got=%b exp=1", req_ready); end
    n_chk++; if (core_operand !== 32'h0 || core_start !== 3'b000) begin n_err++; $display("FAIL rstw_outputs got=%h/%b exp=0/000", core_operand, core_start); end
    pulse_done(3'b111, 32'h6, 32'h6, 32'h6);          // late done
    repeat (3) step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstw_no_rsp got=%b exp=0", rsp_valid); end
    n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstw_idle got=%b exp=1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_all_agree();
    test_no_majority();
    test_timeout();
    test_corrected();
    test_two_disabled();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
